// File: rtl/fir_serial_mac.sv
// rtl/fir_serial_mac.sv - programmable FIR filter using one shared signed MAC over a circular delay line
module fir_serial_mac #(
   parameter int TAPS   = 32,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     coef_wr_en,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] Data_In,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  Data_Out,
   output logic                     busy
);
   localparam int AW = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;
   localparam logic [AW:0]   TAPS_W = (AW+1)'(TAPS);
   localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   state_t state, state_nx;

   logic signed [DATA_W-1:0] buf_mem  [TAPS];
   logic signed [COEF_W-1:0] coef_mem [TAPS];
   logic [AW-1:0]            wr_ptr, k, rd_idx, ptr_nx;
   logic signed [OUT_W-1:0]  acc, acc_nx;
   logic signed [PW-1:0]     prod;
   logic                     accept, coef_we, last_tap;

   assign accept   = in_valid && in_ready;
   assign coef_we  = coef_wr_en && (state == IDLE) && ({1'b0, coef_addr} < TAPS_W);
   assign last_tap = (k == LAST);

   // Pointer arithmetic wraps explicitly so TAPS need not be a power of two
   always_comb begin
      ptr_nx = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (wr_ptr >= k)
         rd_idx = wr_ptr - k;
      else
         rd_idx = AW'({1'b0, wr_ptr} + TAPS_W - {1'b0, k});
      prod   = coef_mem[k] * buf_mem[rd_idx];
      acc_nx = acc + OUT_W'(prod);
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nx = MAC;
         end
         MAC: begin
            if (last_tap) state_nx = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         k        <= '0;
         acc      <= '0;
         Data_Out <= '0;
         for (int i = 0; i < TAPS; i++) begin
            buf_mem[i]  <= '0;
            coef_mem[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (coef_we) coef_mem[coef_addr] <= coef_data;
         if (accept) begin
            buf_mem[ptr_nx] <= Data_In;
            wr_ptr          <= ptr_nx;
            acc             <= '0;
            k               <= '0;
         end else if (state == MAC) begin
            acc <= acc_nx;
            // Final sum goes straight to the output register on the last tap
            if (last_tap) Data_Out <= acc_nx;
            else          k        <= k + 1'b1;
         end
      end
   end
endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
Parametrised, programmable-coefficient successor to the team's fixed 32-tap parallel FIR. Uses a single time-multiplexed signed multiply-accumulate over a circular delay line, so area scales with TAPS only in storage. Coefficients are runtime-loadable. Sample input and result output each use a valid/ready handshake. Sits between the sample source (ADC front end / test generator) and downstream decimation or output logic.

Parameters:
TAPS, 32, number of filter taps (>=2, any integer, not required to be a power of two)
DATA_W, 8, input sample width, signed two's complement
COEF_W, 8, coefficient width, signed two's complement
OUT_W, DATA_W+COEF_W+$clog2(TAPS), result width, full precision, never truncated or saturated

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-high; clears all state
coef_wr_en  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index k (h[k] multiplies x[n-k])
coef_data  in  COEF_W  signed coefficient value
in_valid  in  1  Data_In valid
in_ready  out  1  block can accept a sample
Data_In  in  DATA_W  signed input sample
out_valid  out  1  Data_Out valid
out_ready  in  1  downstream accepts Data_Out
Data_Out  out  OUT_W  signed filter result y[n] = sum h[k]*x[n-k], k=0..TAPS-1
busy  out  1  high in MAC or OUT state

Behaviour:
- Reset (async, active-high): state=IDLE, delay line all 0, coefficients all 0, wr_ptr=0, tap counter=0, accumulator=0, Data_Out=0, out_valid=0. in_ready=(state==IDLE), so it reads 1 during reset. Reset mid-MAC or mid-OUT aborts the result; no output is produced for that sample.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, write Data_In at wr_ptr+1 (mod TAPS, explicit wrap), which becomes the new wr_ptr. Clear the accumulator and k, then go to MAC.
  - MAC: one product per cycle: acc += h[k] * buf[(wr_ptr-k) mod TAPS], k++. After the edge that processes k=TAPS-1, go to OUT. Data_Out is loaded with the final sum and out_valid is set on that same edge.
  - OUT: out_valid=1. Data_Out is held stable while out_valid&!out_ready. On out_ready, out_valid=0 on the next edge and the state returns to IDLE.
- Latency: out_valid rises exactly TAPS clock edges after the accepting edge. Minimum sample period is TAPS+2 cycles. in_ready=0 in MAC and OUT; in_valid is ignored there.
- Arithmetic: product is signed DATA_W+COEF_W bits, sign-extended to OUT_W before accumulation. OUT_W guarantees no overflow for any inputs.
- Coefficient writes:
  - Take effect on the edge when coef_wr_en=1 and state==IDLE.
  - Ignored (no effect) when busy=1.
  - A write and a sample accept on the same IDLE edge are both performed; the MAC uses the new coefficient.
  - coef_addr >= TAPS is ignored.
- Data_Out holds its last value after the handshake until the next result is loaded.

Test Plan:
- Reset values: assert reset mid-MAC -> out_valid=0, Data_Out=0, in_ready=1 immediately (async). After release, an impulse gives all-zero output because coefficients were cleared.
- Impulse response, TAPS=4, coefs {1,2,3,4}: samples 1,0,0,0,0 -> outputs 1,2,3,4,0. Each out_valid arrives 4 edges after its accept.
- Signed extremes, TAPS=32, all coefs -128, 32 samples of -128 -> 32nd output = +524288 (21-bit, no overflow). Coefs +127, samples -128 ×32 -> -520192.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> Data_Out stable, in_ready=0, in_valid pulses ignored. Release -> out_valid drops next edge, in_ready=1.
- Coefficient write while busy: write h[0]=5 during MAC -> ignored, result unchanged. Write in IDLE coincident with sample accept -> the new h[0] is used in that result.
- Wrap-around, TAPS=5 (non-power-of-two), coefs {1,1,1,1,1}, ramp 1..12 -> steady-state outputs are sums of the last 5 samples (15,20,25,...). Results match the golden model across pointer wrap.
